// File: rtl/cache_pkg.sv
// Shared types and width helpers for the set-associative write-back cache.
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        REFILL    = 2'd2,
        RESPOND   = 2'd3
    } state_e;

    // Tag storage is sized for the widest supported address; unused upper
    // bits stay zero and are trimmed by synthesis.
    localparam int TAG_MAX_W = 32;

    typedef struct packed {
        logic                 valid;
        logic                 dirty;
        logic [TAG_MAX_W-1:0] tag;
    } line_meta_t;

    // Widths are clamped to 1 so single-word blocks, single sets or a
    // single way never produce zero-width vectors.
    function automatic int off_w(input int words_per_block);
        return (words_per_block > 1) ? $clog2(words_per_block) : 1;
    endfunction

    function automatic int idx_w(input int sets);
        return (sets > 1) ? $clog2(sets) : 1;
    endfunction

    function automatic int way_w(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

    function automatic int tag_w(input int addr_w, input int words_per_block, input int sets);
        return addr_w - 2 - $clog2(words_per_block) - $clog2(sets);
    endfunction

endpackage

// File: rtl/cache_lru_tracker.sv
// True-LRU bookkeeping per set using per-way age counters (0 = most recent).
// Reset clears all ages; ties are resolved as ways get filled, and while ties
// exist the cache picks invalid ways first anyway.
module cache_lru_tracker
    import cache_pkg::*;
#(
    parameter int SETS = 2,
    parameter int WAYS = 2
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   access_en,
    input  logic [idx_w(SETS)-1:0] access_set,
    input  logic [way_w(WAYS)-1:0] access_way,
    input  logic [idx_w(SETS)-1:0] query_set,
    output logic [way_w(WAYS)-1:0] victim_way
);

    localparam int WAY_W = way_w(WAYS);
    localparam logic [WAY_W-1:0] AGE_MAX = WAY_W'(WAYS - 1);

    logic [WAY_W-1:0] age [SETS][WAYS];

    // Accessed way becomes youngest; ways not older than it age by one.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < SETS; s++)
                for (int w = 0; w < WAYS; w++)
                    age[s][w] <= '0;
        end else if (access_en) begin
            for (int w = 0; w < WAYS; w++) begin
                if (WAY_W'(w) == access_way)
                    age[access_set][w] <= '0;
                else if (age[access_set][w] <= age[access_set][access_way] &&
                         age[access_set][w] != AGE_MAX)
                    age[access_set][w] <= age[access_set][w] + 1'b1;
            end
        end
    end

    // Victim is the oldest way of the queried set, lowest index on a tie.
    always_comb begin
        logic [WAY_W-1:0] best_age;
        victim_way = '0;
        best_age   = age[query_set][0];
        for (int w = 1; w < WAYS; w++) begin
            if (age[query_set][w] > best_age) begin
                best_age   = age[query_set][w];
                victim_way = WAY_W'(w);
            end
        end
    end

endmodule

// File: rtl/set_assoc_back_cache.sv
// N-way set-associative write-back, write-allocate cache with LRU replacement.
// Memory traffic moves one word per done pulse. Optional macro CACHE_STATS_EN
// builds saturating hit/miss counters; otherwise both counter ports read 0.
//
// state     | meaning
// IDLE      | wait for cpu_req, look up tag, serve hits directly
// WRITEBACK | copy dirty victim line to memory, word 0 upward
// REFILL    | fetch requested block, then perform pending access
// RESPOND   | cpu_ack pulse (suppressed if cpu_req was dropped)
module set_assoc_back_cache
    import cache_pkg::*;
#(
    parameter int ADDR_W          = 10,
    parameter int DATA_W          = 32,
    parameter int WORDS_PER_BLOCK = 4,
    parameter int SETS            = 2,
    parameter int WAYS            = 2
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              cpu_req,
    input  logic              read_write_cache,
    input  logic [ADDR_W-1:0] address_cache,
    input  logic [DATA_W-1:0] write_data_cache,
    output logic [DATA_W-1:0] read_data_cache,
    output logic              cpu_ack,
    output logic              hit_miss,
    output logic              read_write_mem,
    output logic              mem_req,
    output logic [ADDR_W-1:0] address_mem,
    output logic [DATA_W-1:0] write_data_mem,
    input  logic [DATA_W-1:0] read_data_mem,
    input  logic              done,
    output logic [15:0]       hit_count,
    output logic [15:0]       miss_count
);

    localparam int OFF_W = off_w(WORDS_PER_BLOCK);
    localparam int IDX_W = idx_w(SETS);
    localparam int WAY_W = way_w(WAYS);
    localparam int TAG_W = tag_w(ADDR_W, WORDS_PER_BLOCK, SETS);

    function automatic logic [OFF_W-1:0] addr_off(input logic [ADDR_W-1:0] a);
        return OFF_W'(32'(a >> 2) % 32'(WORDS_PER_BLOCK));
    endfunction

    function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] a);
        return IDX_W'((32'(a >> 2) / 32'(WORDS_PER_BLOCK)) % 32'(SETS));
    endfunction

    function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] a);
        return TAG_W'(32'(a >> 2) / 32'(WORDS_PER_BLOCK * SETS));
    endfunction

    function automatic logic [ADDR_W-1:0] block_addr(input logic [TAG_W-1:0] t,
                                                     input logic [IDX_W-1:0] i,
                                                     input logic [OFF_W-1:0] k);
        return ADDR_W'(((32'(t) * 32'(SETS) + 32'(i)) * 32'(WORDS_PER_BLOCK) + 32'(k)) << 2);
    endfunction

    state_e            state;
    line_meta_t        meta     [SETS][WAYS];
    logic [DATA_W-1:0] data_arr [SETS][WAYS][WORDS_PER_BLOCK];

    logic [ADDR_W-1:0] req_addr;
    logic              req_rw;
    logic [DATA_W-1:0] req_wdata;
    logic              req_live;
    logic [WAY_W-1:0]  tgt_way;
    logic [OFF_W-1:0]  word_k;

    logic [IDX_W-1:0]  lk_idx, rq_idx;
    logic [TAG_W-1:0]  lk_tag, rq_tag;
    logic [OFF_W-1:0]  lk_off, rq_off;
    assign lk_idx = addr_idx(address_cache);
    assign lk_tag = addr_tag(address_cache);
    assign lk_off = addr_off(address_cache);
    assign rq_idx = addr_idx(req_addr);
    assign rq_tag = addr_tag(req_addr);
    assign rq_off = addr_off(req_addr);

    logic             hit, inv_found;
    logic [WAY_W-1:0] hit_way, inv_way, lru_victim, miss_way;

    // Tag lookup for the incoming request: first matching way, first invalid way.
    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!hit && meta[lk_idx][w].valid && meta[lk_idx][w].tag == TAG_MAX_W'(lk_tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!inv_found && !meta[lk_idx][w].valid) begin
                inv_found = 1'b1;
                inv_way   = WAY_W'(w);
            end
        end
    end
    assign miss_way = inv_found ? inv_way : lru_victim;

    // Word being issued: the current one when raising mem_req, the next one on done.
    logic             last_word, word_done;
    logic [OFF_W-1:0] k_sel;
    logic [ADDR_W-1:0] wb_addr, rf_addr;
    assign last_word = (word_k == OFF_W'(WORDS_PER_BLOCK - 1));
    assign word_done = mem_req && done;
    assign k_sel     = word_done ? word_k + 1'b1 : word_k;
    assign wb_addr   = block_addr(meta[rq_idx][tgt_way].tag[TAG_W-1:0], rq_idx, k_sel);
    assign rf_addr   = block_addr(rq_tag, rq_idx, k_sel);

    logic              lru_en, fill_we, cpu_we;
    logic [IDX_W-1:0]  lru_set, cpu_set;
    logic [WAY_W-1:0]  lru_way, cpu_way;
    logic [OFF_W-1:0]  cpu_off;
    logic [DATA_W-1:0] cpu_wdata;

    // Array/LRU update strobes for hits and for the final refill word.
    always_comb begin
        lru_en    = 1'b0;
        lru_set   = lk_idx;
        lru_way   = hit_way;
        fill_we   = 1'b0;
        cpu_we    = 1'b0;
        cpu_set   = lk_idx;
        cpu_way   = hit_way;
        cpu_off   = lk_off;
        cpu_wdata = write_data_cache;
        if (state == IDLE && cpu_req && hit) begin
            lru_en = 1'b1;
            cpu_we = read_write_cache;
        end
        if (state == REFILL && word_done) begin
            fill_we = 1'b1;
            if (last_word) begin
                lru_en    = 1'b1;
                lru_set   = rq_idx;
                lru_way   = tgt_way;
                cpu_we    = req_rw;
                cpu_set   = rq_idx;
                cpu_way   = tgt_way;
                cpu_off   = rq_off;
                cpu_wdata = req_wdata;
            end
        end
    end

    cache_lru_tracker #(.SETS(SETS), .WAYS(WAYS)) u_lru (
        .clock      (clock),
        .reset_n    (reset_n),
        .access_en  (lru_en),
        .access_set (lru_set),
        .access_way (lru_way),
        .query_set  (lk_idx),
        .victim_way (lru_victim)
    );

    // Data storage, not reset; a CPU store lands after the fill word so it wins.
    always_ff @(posedge clock) begin
        if (fill_we) data_arr[rq_idx][tgt_way][word_k] <= read_data_mem;
        if (cpu_we)  data_arr[cpu_set][cpu_way][cpu_off] <= cpu_wdata;
    end

    // Control FSM, metadata and all registered outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            for (int s = 0; s < SETS; s++)
                for (int w = 0; w < WAYS; w++)
                    meta[s][w] <= '0;
            req_addr        <= '0;
            req_rw          <= 1'b0;
            req_wdata       <= '0;
            req_live        <= 1'b0;
            tgt_way         <= '0;
            word_k          <= '0;
            cpu_ack         <= 1'b0;
            hit_miss        <= 1'b0;
            read_data_cache <= '0;
            mem_req         <= 1'b0;
            read_write_mem  <= 1'b0;
            address_mem     <= '0;
            write_data_mem  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cpu_req) begin
                        req_addr  <= address_cache;
                        req_rw    <= read_write_cache;
                        req_wdata <= write_data_cache;
                        req_live  <= 1'b1;
                        word_k    <= '0;
                        if (hit) begin
                            if (read_write_cache) meta[lk_idx][hit_way].dirty <= 1'b1;
                            else read_data_cache <= data_arr[lk_idx][hit_way][lk_off];
                            cpu_ack  <= 1'b1;
                            hit_miss <= 1'b1;
                            state    <= RESPOND;
                        end else begin
                            tgt_way <= miss_way;
                            if (meta[lk_idx][miss_way].valid && meta[lk_idx][miss_way].dirty)
                                state <= WRITEBACK;
                            else
                                state <= REFILL;
                        end
                    end
                end
                WRITEBACK: begin
                    if (!cpu_req) req_live <= 1'b0;
                    if (!mem_req) begin
                        mem_req        <= 1'b1;
                        read_write_mem <= 1'b1;
                        address_mem    <= wb_addr;
                        write_data_mem <= data_arr[rq_idx][tgt_way][k_sel];
                    end else if (done) begin
                        if (last_word) begin
                            mem_req <= 1'b0;
                            word_k  <= '0;
                            state   <= REFILL;
                        end else begin
                            word_k         <= k_sel;
                            address_mem    <= wb_addr;
                            write_data_mem <= data_arr[rq_idx][tgt_way][k_sel];
                        end
                    end
                end
                REFILL: begin
                    if (!cpu_req) req_live <= 1'b0;
                    if (!mem_req) begin
                        mem_req        <= 1'b1;
                        read_write_mem <= 1'b0;
                        address_mem    <= rf_addr;
                        write_data_mem <= '0;
                    end else if (done) begin
                        if (last_word) begin
                            mem_req                 <= 1'b0;
                            meta[rq_idx][tgt_way]   <= '{valid: 1'b1, dirty: req_rw,
                                                         tag: TAG_MAX_W'(rq_tag)};
                            if (!req_rw)
                                read_data_cache <= (rq_off == word_k) ? read_data_mem
                                                                      : data_arr[rq_idx][tgt_way][rq_off];
                            cpu_ack  <= req_live && cpu_req;
                            hit_miss <= 1'b0;
                            state    <= RESPOND;
                        end else begin
                            word_k      <= k_sel;
                            address_mem <= rf_addr;
                        end
                    end
                end
                RESPOND: begin
                    cpu_ack  <= 1'b0;
                    hit_miss <= 1'b0;
                    req_live <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CACHE_STATS_EN
    // Saturating statistics, counted on each acknowledged access.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (cpu_ack) begin
            if (hit_miss && hit_count != 16'hFFFF)
                hit_count <= hit_count + 1'b1;
            if (!hit_miss && miss_count != 16'hFFFF)
                miss_count <= miss_count + 1'b1;
        end
    end
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif

endmodule

// File: tb/tb_set_assoc_back_cache.sv
// Directed bench for set_assoc_back_cache with a word-addressed memory model
// (word i preloaded with i, two-cycle done latency) and a log of memory words.
module tb_set_assoc_back_cache;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        cpu_req;
    logic        read_write_cache;
    logic [9:0]  address_cache;
    logic [31:0] write_data_cache;
    logic [31:0] read_data_cache;
    logic        cpu_ack;
    logic        hit_miss;
    logic        read_write_mem;
    logic        mem_req;
    logic [9:0]  address_mem;
    logic [31:0] write_data_mem;
    logic [31:0] read_data_mem;
    logic        done;
    logic [15:0] hit_count;
    logic [15:0] miss_count;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] mem [256];
    logic [31:0] log_addr [$];
    logic [31:0] log_rw   [$];
    logic [31:0] log_data [$];

    set_assoc_back_cache dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .cpu_req          (cpu_req),
        .read_write_cache (read_write_cache),
        .address_cache    (address_cache),
        .write_data_cache (write_data_cache),
        .read_data_cache  (read_data_cache),
        .cpu_ack          (cpu_ack),
        .hit_miss         (hit_miss),
        .read_write_mem   (read_write_mem),
        .mem_req          (mem_req),
        .address_mem      (address_mem),
        .write_data_mem   (write_data_mem),
        .read_data_mem    (read_data_mem),
        .done             (done),
        .hit_count        (hit_count),
        .miss_count       (miss_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Memory model: counts two negedges of mem_req, then one-cycle done.
    initial begin
        int lat;
        lat = 0;
        done = 1'b0;
        read_data_mem = '0;
        for (int i = 0; i < 256; i++) mem[i] = 32'(i);
        forever begin
            @(negedge clock);
            if (done) begin
                done = 1'b0;
                lat  = 0;
            end else if (mem_req && reset_n) begin
                lat++;
                if (lat >= 2) begin
                    lat = 0;
                    log_addr.push_back(32'(address_mem));
                    log_rw.push_back(32'(read_write_mem));
                    if (read_write_mem) begin
                        mem[address_mem[9:2]] = write_data_mem;
                        log_data.push_back(write_data_mem);
                    end else begin
                        read_data_mem = mem[address_mem[9:2]];
                        log_data.push_back(read_data_mem);
                    end
                    done = 1'b1;
                end
            end else begin
                lat = 0;
            end
        end
    end

    task automatic clear_log();
        log_addr.delete();
        log_rw.delete();
        log_data.delete();
    endtask

    task automatic access(input logic rw, input logic [9:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output logic hm, output int cyc);
        @(negedge clock);
        read_write_cache = rw;
        address_cache    = a;
        write_data_cache = wd;
        cpu_req          = 1'b1;
        cyc = 0;
        while (!cpu_ack && cyc < 300) begin
            @(negedge clock);
            cyc++;
        end
        check("ack_seen", 32'(cpu_ack), 32'd1);
        rd = read_data_cache;
        hm = hit_miss;
        cpu_req = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        hm;
        int          cyc;
        int          nwrites;

        reset_n = 1'b0;
        cpu_req = 1'b0;
        read_write_cache = 1'b0;
        address_cache = '0;
        write_data_cache = '0;
        repeat (3) @(negedge clock);
        check("rst_ack",      32'(cpu_ack), 0);
        check("rst_hm",       32'(hit_miss), 0);
        check("rst_mem_req",  32'(mem_req), 0);
        check("rst_rw_mem",   32'(read_write_mem), 0);
        check("rst_addr_mem", 32'(address_mem), 0);
        check("rst_wd_mem",   write_data_mem, 0);
        check("rst_rd_cache", read_data_cache, 0);
        reset_n = 1'b1;

        // 1: cold read 0x000
        clear_log();
        access(1'b0, 10'h000, 32'h0, rd, hm, cyc);
        check("s1_hm", 32'(hm), 0);
        check("s1_data", rd, 32'h0);
        check("s1_nwords", 32'(log_addr.size()), 4);
        for (int i = 0; i < 4 && i < log_addr.size(); i++) begin
            check("s1_addr", log_addr[i], 32'(i * 4));
            check("s1_rw", log_rw[i], 0);
        end

        // 2: hit read 0x004
        clear_log();
        access(1'b0, 10'h004, 32'h0, rd, hm, cyc);
        check("s2_hm", 32'(hm), 1);
        check("s2_data", rd, 32'h1);
        check("s2_latency", 32'(cyc), 1);
        check("s2_nwords", 32'(log_addr.size()), 0);
        @(negedge clock);
        check("s2_ack_pulse", 32'(cpu_ack), 0);

        // 3: write miss 0x020, then hit read it back
        clear_log();
        access(1'b1, 10'h020, 32'hDEAD, rd, hm, cyc);
        check("s3_hm", 32'(hm), 0);
        check("s3_nwords", 32'(log_addr.size()), 4);
        if (log_addr.size() == 4) begin
            check("s3_first_addr", log_addr[0], 32'h020);
            check("s3_last_addr", log_addr[3], 32'h02C);
            check("s3_rw", log_rw[0], 0);
        end
        clear_log();
        access(1'b0, 10'h020, 32'h0, rd, hm, cyc);
        check("s3_rd_hm", 32'(hm), 1);
        check("s3_rd_data", rd, 32'hDEAD);

        // 4: read 0x040 evicts clean LRU way
        clear_log();
        access(1'b0, 10'h040, 32'h0, rd, hm, cyc);
        nwrites = 0;
        foreach (log_rw[i]) if (log_rw[i] != 0) nwrites++;
        check("s4_hm", 32'(hm), 0);
        check("s4_data", rd, 32'd16);
        check("s4_nwords", 32'(log_addr.size()), 4);
        check("s4_nwrites", 32'(nwrites), 0);
        if (log_addr.size() == 4) check("s4_first_addr", log_addr[0], 32'h040);

        // 5: read 0x000 evicts dirty 0x020 line
        clear_log();
        access(1'b0, 10'h000, 32'h0, rd, hm, cyc);
        check("s5_hm", 32'(hm), 0);
        check("s5_data", rd, 32'h0);
        check("s5_nwords", 32'(log_addr.size()), 8);
        if (log_addr.size() == 8) begin
            check("s5_wb0_addr", log_addr[0], 32'h020);
            check("s5_wb0_rw",   log_rw[0], 1);
            check("s5_wb0_data", log_data[0], 32'hDEAD);
            check("s5_wb3_addr", log_addr[3], 32'h02C);
            check("s5_wb3_data", log_data[3], 32'd11);
            check("s5_rf0_addr", log_addr[4], 32'h000);
            check("s5_rf0_rw",   log_rw[4], 0);
            check("s5_rf3_addr", log_addr[7], 32'h00C);
        end
        @(negedge clock);
`ifdef CACHE_STATS_EN
        check("s5_hits",   32'(hit_count), 2);
        check("s5_misses", 32'(miss_count), 4);
`else
        check("s5_hits",   32'(hit_count), 0);
        check("s5_misses", 32'(miss_count), 0);
`endif

        // 6: reset during refill of 0x080
        clear_log();
        read_write_cache = 1'b0;
        address_cache    = 10'h080;
        cpu_req          = 1'b1;
        for (int i = 0; i < 100 && !mem_req; i++) @(negedge clock);
        check("s6_refill_req", 32'(mem_req), 1);
        check("s6_refill_rw", 32'(read_write_mem), 0);
        check("s6_refill_addr", 32'(address_mem), 32'h080);
        #2;
        reset_n = 1'b0;
        cpu_req = 1'b0;
        #1;
        check("s6_req_drop", 32'(mem_req), 0);
        check("s6_addr_clr", 32'(address_mem), 0);
        repeat (2) @(negedge clock);
        check("s6_hit_cnt",  32'(hit_count), 0);
        check("s6_miss_cnt", 32'(miss_count), 0);
        check("s6_rd_clr",   read_data_cache, 0);
        reset_n = 1'b1;
        clear_log();
        access(1'b0, 10'h004, 32'h0, rd, hm, cyc);
        check("s6_post_hm", 32'(hm), 0);
        check("s6_post_data", rd, 32'h1);
        check("s6_post_nwords", 32'(log_addr.size()), 4);
        if (log_addr.size() == 4) check("s6_post_addr", log_addr[0], 32'h000);

        repeat (2) @(negedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/set_assoc_back_cache.md
# set_assoc_back_cache

Parametrised N-way set-associative write-back, write-allocate cache placed between the CPU model and `main_mem`. It generalises the direct-mapped write-back cache to configurable ways, sets, block size and widths, with LRU replacement. It uses explicit request/acknowledge handshakes on both sides, and memory traffic is moved one word per `done` pulse.

## Interface
- ADDR_W, 10: byte address width; the low 2 bits are ignored because accesses are word-aligned.
- DATA_W, 32: word width.
- WORDS_PER_BLOCK, 4: words per line; must be a power of two and ≥1.
- SETS, 2: number of sets; must be a power of two.
- WAYS, 2: associativity; must be a power of two and ≥1.
- clock  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- cpu_req  in  1  CPU access request, held until cpu_ack.
- read_write_cache  in  1  1 = write, 0 = read; stable while cpu_req is high.
- address_cache  in  ADDR_W  CPU byte address.
- write_data_cache  in  DATA_W  CPU store data.
- read_data_cache  out  DATA_W  load data, valid during cpu_ack.
- cpu_ack  out  1  one-cycle completion pulse.
- hit_miss  out  1  during cpu_ack: 1 = hit, 0 = miss.
- read_write_mem  out  1  1 = write, 0 = read, toward memory.
- mem_req  out  1  memory word request, held until done.
- address_mem  out  ADDR_W  word-aligned memory byte address.
- write_data_mem  out  DATA_W  write-back data.
- read_data_mem  in  DATA_W  memory read data, valid with done.
- done  in  1  memory completion pulse for the current word.
- hit_count, miss_count  out  16  statistics; see Configuration.

## Operation
- Address split, LSB first: 2 byte bits, log2(WORDS_PER_BLOCK) word-offset bits, log2(SETS) index bits, and the remaining bits form the tag.
- Per line: valid bit, dirty bit, tag, and WORDS_PER_BLOCK data words. Per set: LRU state.
- FSM states: IDLE, WRITEBACK, REFILL, RESPOND.
- IDLE, cpu_req=1, tag match in a valid way (hit):
  - Read: the word is registered into read_data_cache.
  - Write: the word is updated and the line's dirty bit is set.
  - The set's LRU is updated.
  - Go to RESPOND with hit_miss=1.
- IDLE, miss: the victim is the first invalid way, otherwise the LRU way. Go to WRITEBACK if the victim is valid and dirty, else go to REFILL.
- WRITEBACK: issue WORDS_PER_BLOCK memory writes. Each write uses address {victim tag, index, word k, 2'b00}, k = 0..N-1 in ascending order. Advance k on done. After the last word, go to REFILL.
- REFILL: issue WORDS_PER_BLOCK reads of the requested block, k ascending, and store each word on done. After the last word:
  - Set valid=1, dirty=0, and the new tag.
  - Perform the pending access exactly as on a hit (a write sets dirty).
  - Update LRU and go to RESPOND with hit_miss=0.
- RESPOND: pulse cpu_ack for one cycle and return to IDLE. Any new request is evaluated no earlier than the next cycle.
- LRU: true LRU per set. The accessed way becomes most-recent and all other ways age.
- cpu_req dropped before cpu_ack is a protocol violation. The in-flight miss still completes, but no ack is generated.

## Timing
- Reset, asynchronous, while reset_n=0:
  - All valid, dirty and LRU bits are cleared; data arrays are not cleared.
  - FSM goes to IDLE.
  - Outputs are forced to: cpu_ack=0, hit_miss=0, mem_req=0, read_write_mem=0, address_mem=0, write_data_mem=0, read_data_cache=0, counters=0.
  - A reset mid-miss abandons the memory transaction immediately.
- Hit latency: request sampled at edge t, cpu_ack high in cycle t+1.
- Miss latency: 1 + (dirty ? N : 0) + N memory words, each waiting for done, plus 1 cycle of RESPOND.
- mem_req rises on the edge after the state is entered. It falls on the edge that samples done, and rises again on that same edge if more words remain.
- A done pulse outside an outstanding mem_req is ignored.
- Memory address, data and read_write_mem are stable throughout mem_req.

## Configuration
- CACHE_STATS_EN defined: hit_count and miss_count each increment on every cpu_ack according to hit_miss. They saturate at 16'hFFFF and are cleared by reset.
- CACHE_STATS_EN undefined: the counters are not built and both ports are tied to 0.

## Structure
- Package cache_pkg holds:
  - the FSM state enum {IDLE, WRITEBACK, REFILL, RESPOND};
  - derived width functions (offset, index and tag widths via $clog2);
  - the line-metadata struct {valid, dirty, tag}.
- Sub-module cache_lru_tracker: per-set LRU state; it takes an access way and produces the victim way.

## Test plan
Defaults throughout; memory is preloaded with word i = i.
1. Cold read 0x000 → 4 memory reads at 0x000, 0x004, 0x008, 0x00C; ack with hit_miss=0 and data 0.
2. Read 0x004 → ack one cycle after the request, hit_miss=1, data 1, and no mem_req.
3. Write 0x020 with 0xDEAD → refill of 0x020 to 0x02C into way 1; then reading 0x020 hits with data 0xDEAD.
4. Read 0x040 → evicts clean way 0 (LRU) with no memory writes; data 16.
5. Read 0x000 → evicts dirty 0x020 line: 4 writes at 0x020 to 0x02C with the first word 0xDEAD, then 4 refill reads; data 0.
6. Assert reset_n=0 during REFILL → mem_req drops at once. After release, reading 0x004 misses.
   - With CACHE_STATS_EN defined, the counters equal 0 after reset.
